// File: rtl/multi_clk_divider.sv
// Multi-channel programmable clock divider: N_CH independent 50%-duty square waves
// with per-channel enable, shadowed half-period updates at period boundaries and toggle ticks.
module multi_clk_divider #(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 20,
  parameter int DEFAULT_HALF = 390625,
  parameter int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_half,
  input  logic              sync,
  output logic [N_CH-1:0]   out,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   pending
);

  localparam logic [CNT_W-1:0] RESET_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  // A zero half-period would never match count == active-1 sensibly; clamp to 1.
  logic [CNT_W-1:0] wr_val;
  assign wr_val = (wr_half == '0) ? ONE : wr_half;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] shadow;
    logic             pend;
    logic             out_q;
    logic             tick_q;
    logic             wr_hit;
    logic             at_end;

    // Out-of-range channel numbers match no channel, so they are dropped naturally.
    assign wr_hit = wr_en && (32'(wr_ch) == i);
    assign at_end = (count == active - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count  <= '0;
        active <= RESET_HALF;
        shadow <= RESET_HALF;
        pend   <= 1'b0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        if (sync || !en[i]) begin
          count  <= '0;
          out_q  <= 1'b0;
          tick_q <= 1'b0;
          if (pend) begin
            active <= shadow;
            pend   <= 1'b0;
          end
        end else if (at_end) begin
          count  <= '0;
          out_q  <= ~out_q;
          tick_q <= 1'b1;
          // Swap only on the high->low toggle so a full period is never split.
          if (pend && out_q) begin
            active <= shadow;
            pend   <= 1'b0;
          end
        end else begin
          count  <= count + ONE;
          tick_q <= 1'b0;
        end
        // NOTE: non-blocking semantics make this later write win over the apply above,
        // while the apply still reads the pre-edge shadow value.
        if (wr_hit) begin
          shadow <= wr_val;
          pend   <= 1'b1;
        end
      end
    end

    assign out[i]     = out_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend;
  end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed bench for multi_clk_divider: small reset half-period keeps runs short;
// a second 3-channel instance covers the out-of-range channel write.
module tb_multi_clk_divider;

  localparam int DH = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  en;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [19:0] wr_half;
  logic        sync;
  logic [3:0]  out, tick, pending;

  logic [2:0]  en3;
  logic        wr_en3;
  logic [1:0]  wr_ch3;
  logic [19:0] wr_half3;
  logic [2:0]  out3, tick3, pending3;

  int n_vec = 0;
  int n_err = 0;

  multi_clk_divider #(.N_CH(4), .CNT_W(20), .DEFAULT_HALF(DH)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_half(wr_half), .sync(sync), .out(out), .tick(tick), .pending(pending)
  );

  multi_clk_divider #(.N_CH(3), .CNT_W(20), .DEFAULT_HALF(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .wr_en(wr_en3), .wr_ch(wr_ch3),
    .wr_half(wr_half3), .sync(sync), .out(out3), .tick(tick3), .pending(pending3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [19:0] half);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_half = half;
    clk_edge();
    wr_en   = 1'b0;
  endtask

  // Expected level/strobe of a channel started from count 0 with constant half-period h.
  function automatic logic exp_out(input int e, input int h);
    return ((e / h) % 2) == 1;
  endfunction

  function automatic logic exp_tick(input int e, input int h);
    return (e > 0) && ((e % h) == 0);
  endfunction

  initial begin
    logic [3:0] eo, et, ep;
    logic [2:0] eo3;
    int hs [4];
    hs = '{3, 4, 5, 6};

    rst_n = 1'b0; en = '0; wr_en = 1'b0; wr_ch = '0; wr_half = '0; sync = 1'b0;
    en3 = '0; wr_en3 = 1'b0; wr_ch3 = '0; wr_half3 = '0;
    #12;
    check("reset_out", 32'(out), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_pending", 32'(pending), 32'h0);
    check("reset_out3", 32'(out3), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Default half-period on channel 0 only.
    en = 4'b0001;
    for (int e = 1; e <= 26; e++) begin
      clk_edge();
      check("default_out", 32'(out), 32'(exp_out(e, DH)));
      check("default_tick", 32'(tick), 32'(exp_tick(e, DH)));
    end
    en = 4'b0000;
    clk_edge();
    check("disable_out", 32'(out), 32'h0);

    // Out-of-range channel write on the 3-channel build.
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_half3 = 20'd1;
    clk_edge();
    wr_en3 = 1'b0;
    check("oob_pending", 32'(pending3), 32'h0);
    en3 = 3'b111;
    for (int e = 1; e <= 5; e++) begin
      clk_edge();
      eo3 = exp_out(e, 4) ? 3'b111 : 3'b000;
      check("oob_out", 32'(out3), 32'(eo3));
    end

    // Fast mode: write while disabled, pending lives exactly one cycle.
    wr(2'd1, 20'd3);
    check("fast_pend_set", 32'(pending), 32'h2);
    clk_edge();
    check("fast_pend_clr", 32'(pending), 32'h0);
    en = 4'b0010;
    for (int e = 1; e <= 15; e++) begin
      clk_edge();
      check("fast_out", 32'(out), 32'(exp_out(e, 3)) << 1);
      check("fast_tick", 32'(tick), 32'(exp_tick(e, 3)) << 1);
    end

    // Glitch-free update written during the high phase.
    wr(2'd1, 20'd5);
    check("upd_out_a", 32'(out), 32'h2);
    check("upd_pend_a", 32'(pending), 32'h2);
    clk_edge();
    check("upd_out_b", 32'(out), 32'h2);
    check("upd_pend_b", 32'(pending), 32'h2);
    clk_edge();
    check("upd_fall_out", 32'(out), 32'h0);
    check("upd_fall_tick", 32'(tick), 32'h2);
    check("upd_fall_pend", 32'(pending), 32'h0);
    for (int e = 1; e <= 10; e++) begin
      clk_edge();
      check("upd_out", 32'(out), 32'(exp_out(e, 5)) << 1);
      check("upd_tick", 32'(tick), 32'(exp_tick(e, 5)) << 1);
    end

    // Zero half-period behaves as 1.
    en = 4'b0000;
    wr(2'd1, 20'd0);
    check("zero_pend", 32'(pending), 32'h2);
    clk_edge();
    en = 4'b0010;
    for (int e = 1; e <= 6; e++) begin
      clk_edge();
      check("zero_out", 32'(out), 32'(e % 2) << 1);
      check("zero_tick", 32'(tick), 32'h2);
    end

    // Write coinciding with an apply: 7 applied, 2 stays pending.
    en = 4'b0000;
    wr(2'd2, 20'd7);
    check("coll_pend_a", 32'(pending), 32'h4);
    wr(2'd2, 20'd2);
    check("coll_pend_b", 32'(pending), 32'h4);
    en = 4'b0100;
    for (int e = 1; e <= 16; e++) begin
      clk_edge();
      eo = (((e >= 7) && (e < 14)) || (e >= 16)) ? 4'h4 : 4'h0;
      et = ((e == 7) || (e == 14) || (e == 16)) ? 4'h4 : 4'h0;
      ep = (e < 14) ? 4'h4 : 4'h0;
      check("coll_out", 32'(out), 32'(eo));
      check("coll_tick", 32'(tick), 32'(et));
      check("coll_pend", 32'(pending), 32'(ep));
    end

    // Sync realigns four channels at half-periods 3..6.
    en = 4'b0000;
    wr(2'd0, 20'd3);
    wr(2'd1, 20'd4);
    wr(2'd2, 20'd5);
    wr(2'd3, 20'd6);
    clk_edge();
    check("sync_pend", 32'(pending), 32'h0);
    en = 4'b1111;
    repeat (6) clk_edge();
    check("sync_pre_out", 32'(out), 32'he);
    sync = 1'b1;
    clk_edge();
    sync = 1'b0;
    check("sync_out", 32'(out), 32'h0);
    check("sync_tick", 32'(tick), 32'h0);
    for (int e = 1; e <= 8; e++) begin
      clk_edge();
      for (int i = 0; i < 4; i++) begin
        eo[i] = exp_out(e, hs[i]);
        et[i] = exp_tick(e, hs[i]);
      end
      check("sync_run_out", 32'(out), 32'(eo));
      check("sync_run_tick", 32'(tick), 32'(et));
    end

    // Async reset between edges while channel 0 is high with an update pending.
    clk_edge();
    check("ar_pre_out", 32'(out[0]), 32'h1);
    wr(2'd0, 20'd9);
    check("ar_pre_out2", 32'(out[0]), 32'h1);
    check("ar_pre_pend", 32'(pending[0]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out", 32'(out), 32'h0);
    check("ar_tick", 32'(tick), 32'h0);
    check("ar_pend", 32'(pending), 32'h0);
    #1;
    rst_n = 1'b1;
    en = 4'b0001;
    for (int e = 1; e <= 13; e++) begin
      clk_edge();
      check("ar_run_out", 32'(out), 32'(exp_out(e, DH)));
      check("ar_run_tick", 32'(tick), 32'(exp_tick(e, DH)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
